weight_tile: RTL and testbench

Parametrised weight-holding tile for the convolution array. It loads one kernel weight vector of CH channels from its memory bank, then sweeps a kernel (KW×KH) × output-map (OW×OH) schedule. On each step it takes weights from the west neighbour or the north neighbour, or restores its own loaded copy. It also provides the x/y/X/Y sweep counters and a finish pulse, and it replaces the fixed 16-channel, 3×3 / 19×19 weight register.

---
 rtl/weight_tile_pkg.sv | 23 ++
 rtl/weight_tile_if.sv | 41 ++++
 rtl/weight_tile_wrap_counter.sv | 27 ++
 rtl/weight_tile.sv | 157 +++++++++++++++
 tb/tb_weight_tile.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_tile_pkg.sv
// Shared types and helpers for the weight tile and its sweep counters.
package weight_tile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_WEST,
        SRC_NORTH,
        SRC_HOME
    } weight_src_t;

    // Counter width for a 0..max-1 range; a single-value range still gets one bit.
    function automatic int cnt_w(input int max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

endpackage

// File: rtl/weight_tile_if.sv
// Bus bundle between a weight tile, its memory bank, its neighbours and the MAC.
interface weight_tile_if #(
    parameter int CH = 16,
    parameter int W  = 8,
    parameter int AW = 4,
    parameter int KW = 3,
    parameter int KH = 3,
    parameter int OW = 19,
    parameter int OH = 19
);
    localparam int XW  = weight_tile_pkg::cnt_w(KW);
    localparam int YW  = weight_tile_pkg::cnt_w(KH);
    localparam int MXW = weight_tile_pkg::cnt_w(OW);
    localparam int MYW = weight_tile_pkg::cnt_w(OH);

    logic                   start;
    logic                   en;
    logic [AW-1:0]          base_addr;
    logic [CH*AW-1:0]       w_raddr;
    logic signed [CH*W-1:0] w_rdata;
    logic signed [CH*W-1:0] west_in;
    logic signed [CH*W-1:0] north_in;
    logic signed [CH*W-1:0] w_out;
    logic                   valid;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [MXW-1:0]         X;
    logic [MYW-1:0]         Y;
    logic                   finish;

    modport master (
        output start, en, base_addr, w_rdata, west_in, north_in,
        input  w_raddr, w_out, valid, x, y, X, Y, finish
    );

    modport slave (
        input  start, en, base_addr, w_rdata, west_in, north_in,
        output w_raddr, w_out, valid, x, y, X, Y, finish
    );

endinterface

// File: rtl/weight_tile_wrap_counter.sv
// Modulo-MAX counter with terminal-count flag; chained to build the sweep counters.
module wrap_counter
    import weight_tile_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic                    en,
    output logic [cnt_w(MAX)-1:0]   q,
    output logic                    last
);

    localparam int QW = cnt_w(MAX);
    localparam logic [QW-1:0] TOP = QW'(MAX - 1);

    assign last = (q == TOP);

    always_ff @(posedge clk) begin
        if (xrst) begin
            q <= '0;
        end else if (en) begin
            q <= last ? '0 : q + QW'(1);
        end
    end

endmodule

// File: rtl/weight_tile.sv
// Weight-holding tile: loads one CH-channel weight vector, then sweeps the
// kernel x output-map schedule passing weights west->east / north->south.
module weight_tile
    import weight_tile_pkg::*;
#(
    parameter int CH = 16,
    parameter int W  = 8,
    parameter int AW = 4,
    parameter int KW = 3,
    parameter int KH = 3,
    parameter int OW = 19,
    parameter int OH = 19
) (
    input  logic          clk,
    input  logic          xrst,
    weight_tile_if.slave  bus
);

    localparam int XW  = cnt_w(KW);
    localparam int YW  = cnt_w(KH);
    localparam int MXW = cnt_w(OW);
    localparam int MYW = cnt_w(OH);

    state_t                 state;
    state_t                 state_nx;
    logic                   step;
    logic                   cnt_clr;
    logic                   en_y;
    logic                   en_mx;
    logic                   en_my;
    logic                   last_x;
    logic                   last_y;
    logic                   last_mx;
    logic                   last_my;
    logic                   sweep_last;
    logic [XW-1:0]          cnt_x;
    logic [YW-1:0]          cnt_y;
    logic [MXW-1:0]         cnt_mx;
    logic [MYW-1:0]         cnt_my;
    logic [AW-1:0]          addr_q;
    logic signed [CH*W-1:0] w_q;
    logic signed [CH*W-1:0] home_q;
    logic signed [CH*W-1:0] w_nx;
    weight_src_t            src;

    always_ff @(posedge clk) begin
        if (xrst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step     = 1'b0;
        unique case (state)
            IDLE: if (bus.start) state_nx = ADDR;
            ADDR: state_nx = CAPT;
            CAPT: state_nx = RUN;
            RUN: begin
                if (bus.en) begin
                    step = 1'b1;
                    if (sweep_last) state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Each counter advances only when every faster counter wraps on this step.
    assign cnt_clr    = xrst | (state == CAPT);
    assign en_y       = step & last_x;
    assign en_mx      = en_y & last_y;
    assign en_my      = en_mx & last_mx;
    assign sweep_last = last_x & last_y & last_mx & last_my;

    wrap_counter #(.MAX(KW)) u_cnt_x (
        .clk (clk),
        .xrst(cnt_clr),
        .en  (step),
        .q   (cnt_x),
        .last(last_x)
    );

    wrap_counter #(.MAX(KH)) u_cnt_y (
        .clk (clk),
        .xrst(cnt_clr),
        .en  (en_y),
        .q   (cnt_y),
        .last(last_y)
    );

    wrap_counter #(.MAX(OW)) u_cnt_mx (
        .clk (clk),
        .xrst(cnt_clr),
        .en  (en_mx),
        .q   (cnt_mx),
        .last(last_mx)
    );

    wrap_counter #(.MAX(OH)) u_cnt_my (
        .clk (clk),
        .xrst(cnt_clr),
        .en  (en_my),
        .q   (cnt_my),
        .last(last_my)
    );

    // End of a kernel row pulls from north; end of the whole kernel restores home.
    always_comb begin
        src = SRC_WEST;
        if (last_x) begin
            src = last_y ? SRC_HOME : SRC_NORTH;
        end
    end

    always_comb begin
        w_nx = w_q;
        case (src)
            SRC_WEST:  w_nx = bus.west_in;
            SRC_NORTH: w_nx = bus.north_in;
            SRC_HOME:  w_nx = home_q;
            default:   w_nx = w_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            addr_q <= '0;
            w_q    <= '0;
            home_q <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                addr_q <= bus.base_addr;
            end
            if (state == CAPT) begin
                w_q    <= bus.w_rdata;
                home_q <= bus.w_rdata;
            end else if (step) begin
                w_q <= w_nx;
            end
        end
    end

    // The bank word is forwarded during CAPT so weights appear two cycles after start.
    assign bus.w_raddr = {CH{addr_q}};
    assign bus.w_out   = (state == CAPT) ? bus.w_rdata : w_q;
    assign bus.valid   = (state == CAPT) || (state == RUN);
    assign bus.finish  = (state == DONE);
    assign bus.x       = cnt_x;
    assign bus.y       = cnt_y;
    assign bus.X       = cnt_mx;
    assign bus.Y       = cnt_my;

endmodule

// File: tb/tb_weight_tile.sv
// Randomized bench for weight_tile against a step-count reference model.
module tb_weight_tile;
    import weight_tile_pkg::*;

    localparam int CH    = 16;
    localparam int W     = 8;
    localparam int AW    = 4;
    localparam int NW    = CH * W;
    localparam int TOTAL = 3 * 3 * 19 * 19;

    logic clk = 1'b0;
    logic xrst;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [W-1:0]  mem [CH][1<<AW];
    logic [NW-1:0] home;

    always #5 clk = ~clk;

    weight_tile_if #(.CH(CH), .W(W), .AW(AW), .KW(3), .KH(3), .OW(19), .OH(19)) bus ();
    weight_tile_if #(.CH(CH), .W(W), .AW(AW), .KW(2), .KH(2), .OW(2), .OH(2)) bus2 ();

    weight_tile #(.CH(CH), .W(W), .AW(AW), .KW(3), .KH(3), .OW(19), .OH(19)) dut (
        .clk (clk),
        .xrst(xrst),
        .bus (bus)
    );

    weight_tile #(.CH(CH), .W(W), .AW(AW), .KW(2), .KH(2), .OW(2), .OH(2)) dut2 (
        .clk (clk),
        .xrst(xrst),
        .bus (bus2)
    );

    // Memory banks with one-cycle registered read, one port per tile.
    always @(posedge clk) begin
        for (int k = 0; k < CH; k++) begin
            bus.w_rdata[k*W +: W]  <= mem[k][bus.w_raddr[k*AW +: AW]];
            bus2.w_rdata[k*W +: W] <= mem[k][bus2.w_raddr[k*AW +: AW]];
        end
    end

    task automatic check(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] bank_word(input logic [AW-1:0] a);
        logic [NW-1:0] r;
        for (int k = 0; k < CH; k++) r[k*W +: W] = mem[k][a];
        return r;
    endfunction

    function automatic logic [NW-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Weight selected by the m-th enabled step (m counted from 0).
    function automatic logic [NW-1:0] exp_w(input int m, input int kw, input int kh,
                                            input logic [NW-1:0] wv, input logic [NW-1:0] nv,
                                            input logic [NW-1:0] hm);
        if (m % kw != kw - 1) return wv;
        if ((m / kw) % kh != kh - 1) return nv;
        return hm;
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_wout"},   bus.w_out, '0);
        check({pfx, "_raddr"},  bus.w_raddr, '0);
        check({pfx, "_valid"},  bus.valid, 1'b0);
        check({pfx, "_finish"}, bus.finish, 1'b0);
        check({pfx, "_x"},      bus.x, '0);
        check({pfx, "_y"},      bus.y, '0);
        check({pfx, "_X"},      bus.X, '0);
        check({pfx, "_Y"},      bus.Y, '0);
    endtask

    task automatic load(input logic [AW-1:0] a);
        bus.base_addr = a;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.base_addr = ~a;
        check("ld_raddr", bus.w_raddr, {CH{a}});
        check("ld_valid_addr", bus.valid, 1'b0);
        tick();
        home = bank_word(a);
        check("ld_wout", bus.w_out, home);
        check("ld_valid", bus.valid, 1'b1);
        check("ld_x", bus.x, '0);
        check("ld_X", bus.X, '0);
    endtask

    task automatic sweep(input int stop_at, input bit rnd, input logic [AW-1:0] a);
        int            n;
        int            cyc;
        int            stall;
        bit            stall_done;
        bit            en_c;
        logic [NW-1:0] want;
        logic [NW-1:0] wv;
        logic [NW-1:0] nv;
        string         pfx;
        n = 0; cyc = 0; stall = 0; stall_done = 1'b0; want = home;
        bus.en = 1'b1;
        tick();
        check("run_entry_wout", bus.w_out, home);
        check("run_entry_valid", bus.valid, 1'b1);
        while (n < TOTAL && n != stop_at && cyc < 20000) begin
            pfx  = (stall > 0) ? "stall" : "run";
            en_c = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
            if (stall > 0) begin
                en_c = 1'b0;
                stall--;
            end
            wv = rnd_vec();
            nv = rnd_vec();
            bus.en        = en_c;
            bus.west_in   = wv;
            bus.north_in  = nv;
            bus.start     = ($urandom_range(0, 39) == 0);
            bus.base_addr = AW'($urandom);
            if (en_c) begin
                want = exp_w(n, 3, 3, wv, nv, home);
                n++;
            end
            tick();
            cyc++;
            if (n < TOTAL) begin
                check({pfx, "_wout"},   bus.w_out, want);
                check({pfx, "_x"},      bus.x, n % 3);
                check({pfx, "_y"},      bus.y, (n / 3) % 3);
                check({pfx, "_X"},      bus.X, (n / 9) % 19);
                check({pfx, "_Y"},      bus.Y, n / 171);
                check({pfx, "_valid"},  bus.valid, 1'b1);
                check({pfx, "_finish"}, bus.finish, 1'b0);
            end
            if (n == 37 && !stall_done) begin
                stall      = 3;
                stall_done = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.en    = 1'b0;
        if (cyc >= 20000) check("sweep_timeout", cyc, 0);
        if (n == TOTAL) begin
            check("done_finish", bus.finish, 1'b1);
            check("done_valid", bus.valid, 1'b0);
            check("done_wout", bus.w_out, home);
            check("done_x", bus.x, '0);
            check("done_Y", bus.Y, '0);
            check("done_raddr", bus.w_raddr, {CH{a}});
            tick();
            check("idle_finish", bus.finish, 1'b0);
            check("idle_valid", bus.valid, 1'b0);
            check("idle_wout", bus.w_out, home);
            check("idle_raddr", bus.w_raddr, {CH{a}});
        end
    endtask

    task automatic run_small();
        logic [AW-1:0] a;
        logic [NW-1:0] h2;
        logic [NW-1:0] wv;
        logic [NW-1:0] nv;
        a  = AW'($urandom_range(0, 15));
        wv = {CH{8'h11}};
        nv = {CH{8'h22}};
        bus2.base_addr = a;
        bus2.start     = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("s_raddr", bus2.w_raddr, {CH{a}});
        tick();
        h2 = bank_word(a);
        check("s_load", bus2.w_out, h2);
        check("s_valid", bus2.valid, 1'b1);
        bus2.en       = 1'b1;
        bus2.west_in  = wv;
        bus2.north_in = nv;
        tick();
        check("s_entry", bus2.w_out, h2);
        for (int m = 0; m < 16; m++) begin
            tick();
            check("s_step", bus2.w_out, exp_w(m, 2, 2, wv, nv, h2));
        end
        check("s_finish", bus2.finish, 1'b1);
        check("s_valid_done", bus2.valid, 1'b0);
        bus2.en = 1'b0;
        tick();
        check("s_idle_finish", bus2.finish, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] a;
        for (int k = 0; k < CH; k++) begin
            for (int j = 0; j < (1 << AW); j++) mem[k][j] = W'($urandom);
            mem[k][5] = W'(k + 1);
        end
        xrst = 1'b1;
        bus.start = 1'b1;  bus.en = 1'b0;  bus.base_addr = 4'hA;
        bus.west_in = '0;  bus.north_in = '0;
        bus2.start = 1'b1; bus2.en = 1'b0; bus2.base_addr = 4'hA;
        bus2.west_in = '0; bus2.north_in = '0;
        tick();
        tick();
        check_zero("rst");
        xrst = 1'b0;
        bus.start = 1'b0;
        bus2.start = 1'b0;
        tick();
        check_zero("post_rst");

        run_small();

        load(4'd5);
        for (int k = 0; k < CH; k++) check("ld_chan", bus.w_out[k*W +: W], k + 1);
        sweep(-1, 1'b1, 4'd5);

        a = AW'($urandom_range(0, 15));
        load(a);
        sweep(63, 1'b0, a);
        check("mid_X", bus.X, 7);
        xrst = 1'b1;
        bus.start = 1'b1;
        bus.en = 1'b1;
        tick();
        tick();
        check_zero("mid_rst");
        xrst = 1'b0;
        bus.start = 1'b0;
        bus.en = 1'b0;
        tick();
        check_zero("mid_post");

        a = AW'($urandom_range(0, 15));
        load(a);
        sweep(-1, 1'b1, a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
